// File: rtl/bscan_dr_ctrl.sv
// -----------------------------------------------------------------------------
// bscan_dr_ctrl
//
// Sequencer for one BSCANE2 USER data register, clocked by TCK. It turns the
// TAP strobes into a fixed-length user DR: CAPTURE loads a readback word,
// SHIFT moves bits LSB-first from TDI towards TDO, and UPDATE hands a
// length-checked command word to fabric logic.
//
// Ports:
//   clk, rst_n        TCK and asynchronous active-low reset
//   test_logic_reset  BSCANE2 RESET, synchronous clear, overrides everything
//   ir_is_user        BSCANE2 SEL, qualifies capture_dr/shift_dr/update_dr
//   capture_dr        BSCANE2 CAPTURE
//   shift_dr          BSCANE2 SHIFT
//   update_dr         BSCANE2 UPDATE
//   tdi, tdo          serial data in / out (tdo is sr[0])
//   rd_data           readback word, sampled on capture
//   cmd_data          command word, stable while cmd_valid is high
//   cmd_valid         command pending
//   cmd_ready         fabric accepts the pending command
//   err_len           sticky: update seen with bit count != DR_WIDTH
//   err_ovf           sticky: valid-length update dropped (command pending)
//   xfer_cnt          accepted commands, wraps
//   dbg_state         FSM state (0 = IDLE, 1 = ARMED)
//   dbg_bit_cnt       current shift count (saturates at DR_WIDTH+1)
//
// Handshake: a command transfers on every rising edge where cmd_valid and
// cmd_ready are both high. cmd_data is held constant while cmd_valid is high
// and no transfer happens. A valid-length update coinciding with a transfer
// reloads cmd_data and keeps cmd_valid high.
// -----------------------------------------------------------------------------
module bscan_dr_ctrl #(
  parameter int DR_WIDTH  = 32,
  parameter int CNT_WIDTH = 16,
  localparam int BCW      = $clog2(DR_WIDTH + 2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 test_logic_reset,
  input  logic                 ir_is_user,
  input  logic                 capture_dr,
  input  logic                 shift_dr,
  input  logic                 update_dr,
  input  logic                 tdi,
  output logic                 tdo,
  input  logic [DR_WIDTH-1:0]  rd_data,
  output logic [DR_WIDTH-1:0]  cmd_data,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic                 err_len,
  output logic                 err_ovf,
  output logic [CNT_WIDTH-1:0] xfer_cnt,
  output logic                 dbg_state,
  output logic [BCW-1:0]       dbg_bit_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  localparam logic [BCW-1:0] LEN_OK  = BCW'(DR_WIDTH);
  localparam logic [BCW-1:0] LEN_SAT = BCW'(DR_WIDTH + 1);

  state_t              state, state_nxt;
  logic [DR_WIDTH-1:0] sr;
  logic [BCW-1:0]      bit_cnt;

  logic do_capture;
  logic do_update;
  logic do_shift;
  logic hs;
  logic len_ok;
  logic load_cmd;
  logic set_ovf;
  logic set_len;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (test_logic_reset) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (do_capture) state_nxt = ARMED;
        ARMED: begin
          if (do_capture)     state_nxt = ARMED;
          else if (do_update) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Strobe decode and update-time decisions. Capture beats update beats
  // shift; update and shift only mean something once a capture has armed
  // the scan. Dropping ir_is_user simply stops all strobes, so a scan that
  // is interrupted resumes where it left off.
  always_comb begin
    do_capture = ir_is_user & capture_dr;
    do_update  = ir_is_user & update_dr & ~capture_dr & (state == ARMED);
    do_shift   = ir_is_user & shift_dr & ~capture_dr & ~update_dr & (state == ARMED);
    hs         = cmd_valid & cmd_ready;
    len_ok     = (bit_cnt == LEN_OK);
    load_cmd   = do_update & len_ok & (~cmd_valid | hs);
    set_ovf    = do_update & len_ok & cmd_valid & ~hs;
    set_len    = do_update & ~len_ok;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= '0;
      bit_cnt   <= '0;
      cmd_data  <= '0;
      cmd_valid <= 1'b0;
      err_len   <= 1'b0;
      err_ovf   <= 1'b0;
      xfer_cnt  <= '0;
    end else if (test_logic_reset) begin
      sr        <= '0;
      bit_cnt   <= '0;
      cmd_data  <= '0;
      cmd_valid <= 1'b0;
      err_len   <= 1'b0;
      err_ovf   <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      if (do_capture) begin
        sr      <= rd_data;
        bit_cnt <= '0;
      end else if (do_shift) begin
        // sr keeps shifting beyond DR_WIDTH bits; the count stops one past
        // the legal length so over-length scans never wrap back to "legal".
        sr <= {tdi, sr[DR_WIDTH-1:1]};
        if (bit_cnt != LEN_SAT) bit_cnt <= bit_cnt + 1'b1;
      end

      if (load_cmd) begin
        cmd_data  <= sr;
        cmd_valid <= 1'b1;
      end else if (hs) begin
        cmd_valid <= 1'b0;
      end

      if (hs)      xfer_cnt <= xfer_cnt + 1'b1;
      if (set_len) err_len  <= 1'b1;
      if (set_ovf) err_ovf  <= 1'b1;
    end
  end

  assign tdo         = sr[0];
  assign dbg_state   = state;
  assign dbg_bit_cnt = bit_cnt;

endmodule

// File: tb/tb_bscan_dr_ctrl.sv
module tb_bscan_dr_ctrl;

  localparam int W  = 32;
  localparam int CW = 8;
  localparam int BW = $clog2(W + 2);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          test_logic_reset = 1'b0;
  logic          ir_is_user = 1'b0;
  logic          capture_dr = 1'b0;
  logic          shift_dr = 1'b0;
  logic          update_dr = 1'b0;
  logic          tdi = 1'b0;
  logic          tdo;
  logic [W-1:0]  rd_data = '0;
  logic [W-1:0]  cmd_data;
  logic          cmd_valid;
  logic          cmd_ready = 1'b0;
  logic          err_len;
  logic          err_ovf;
  logic [CW-1:0] xfer_cnt;
  logic          dbg_state;
  logic [BW-1:0] dbg_bit_cnt;

  bscan_dr_ctrl #(.DR_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .test_logic_reset (test_logic_reset),
    .ir_is_user       (ir_is_user),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr),
    .tdi              (tdi),
    .tdo              (tdo),
    .rd_data          (rd_data),
    .cmd_data         (cmd_data),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .err_len          (err_len),
    .err_ovf          (err_ovf),
    .xfer_cnt         (xfer_cnt),
    .dbg_state        (dbg_state),
    .dbg_bit_cnt      (dbg_bit_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: the DR is a bit queue, head = bit that is on TDO.
  // Capture refills it with rd_data bit0-first, each shift appends TDI at
  // the tail and drops the head. m_n is the true (unsaturated) shift count.
  bit           m_q[$];
  int           m_n;
  bit           m_armed, m_valid, m_len, m_ovf;
  logic [W-1:0] m_data;
  logic [CW-1:0] m_cnt;
  logic [W-1:0] exp_q[$];   // commands expected to be accepted, in order

  function automatic logic [W-1:0] q_word();
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) w[i] = m_q[i];
    return w;
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < W; i++) m_q.push_back(1'b0);
    m_n = 0; m_armed = 0; m_valid = 0; m_len = 0; m_ovf = 0;
    m_data = '0; m_cnt = '0;
    exp_q.delete();
  endtask

  task automatic check_all();
    chk("tdo",       tdo,         m_q[0]);
    chk("cmd_valid", cmd_valid,   m_valid);
    chk("cmd_data",  cmd_data,    m_data);
    chk("err_len",   err_len,     m_len);
    chk("err_ovf",   err_ovf,     m_ovf);
    chk("xfer_cnt",  xfer_cnt,    m_cnt);
    chk("state",     dbg_state,   m_armed);
    chk("bit_cnt",   dbg_bit_cnt, (m_n > W + 1) ? W + 1 : m_n);
  endtask

  // ---------------- driver ----------------
  // Apply one TCK cycle of inputs, advance the model, compare after the edge.
  task automatic step(input bit s, input bit c, input bit sh, input bit u,
                      input bit ti, input bit r, input bit t);
    bit hs, was_valid;
    ir_is_user = s; capture_dr = c; shift_dr = sh; update_dr = u;
    tdi = ti; cmd_ready = r; test_logic_reset = t;
    if (t) begin
      model_reset();
    end else begin
      was_valid = m_valid;
      hs = m_valid && r;
      if (hs) begin
        m_valid = 0;
        m_cnt++;
        if (exp_q.size() > 0) chk("accepted_word", cmd_data, exp_q.pop_front());
      end
      if (s && c) begin
        m_q.delete();
        for (int i = 0; i < W; i++) m_q.push_back(rd_data[i]);
        m_n = 0; m_armed = 1;
      end else if (s && u && m_armed) begin
        m_armed = 0;
        if (m_n == W) begin
          if (was_valid && !hs) m_ovf = 1;
          else begin m_data = q_word(); m_valid = 1; exp_q.push_back(m_data); end
        end else begin
          m_len = 1;
        end
      end else if (s && sh && m_armed) begin
        m_q.push_back(ti);
        void'(m_q.pop_front());
        m_n++;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic tlr_pulse();
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic cap_shift(input logic [W-1:0] rw, input logic [W-1:0] dat,
                           input int n, input bit rnd);
    bit b;
    rd_data = rw;
    step(1, 1, 0, 0, 0, rnd ? 1'($urandom_range(0, 1)) : 1'b0, 0);
    for (int i = 0; i < n; i++) begin
      if (rnd && $urandom_range(0, 9) == 0)
        step(0, 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      b = (i < W) ? dat[i % W] : 1'($urandom_range(0, 1));
      step(1, 0, 1, 0, b, rnd ? 1'($urandom_range(0, 1)) : 1'b0, 0);
    end
  endtask

  task automatic do_update(input bit r);
    step(1, 0, 0, 1, 0, r, 0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit           sel, cap, sh, upd, ti, rdy;
    logic [W-1:0] rd;
    bit           e_tdo, e_valid, e_len, e_state;
    int           e_cnt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w1, w2;
    // sel  cap sh upd ti rdy  rd            tdo vld len st cnt
    tbl[0] = '{1, 0, 0, 1, 0, 0, 32'h0,        0, 0, 0, 0, 0}; // update in IDLE: ignored
    tbl[1] = '{0, 1, 0, 0, 0, 0, 32'hA5A50F0F, 0, 0, 0, 0, 0}; // capture without SEL
    tbl[2] = '{1, 0, 1, 0, 1, 0, 32'h0,        0, 0, 0, 0, 0}; // shift in IDLE: ignored
    tbl[3] = '{1, 1, 0, 0, 0, 0, 32'h3,        1, 0, 0, 1, 0}; // capture
    tbl[4] = '{1, 0, 1, 0, 0, 0, 32'h0,        1, 0, 0, 1, 1}; // shift -> bit1
    tbl[5] = '{0, 0, 1, 0, 1, 0, 32'h0,        1, 0, 0, 1, 1}; // SEL low: held
    tbl[6] = '{1, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 1, 2}; // shift -> bit2
    tbl[7] = '{1, 1, 1, 1, 0, 0, 32'h5,        1, 0, 0, 1, 0}; // capture wins
    tbl[8] = '{1, 0, 1, 1, 0, 0, 32'h0,        1, 0, 1, 0, 0}; // update wins, short

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_tdo", tdo, 0);           chk("rst_valid", cmd_valid, 0);
    chk("rst_data", cmd_data, 0);     chk("rst_err_len", err_len, 0);
    chk("rst_err_ovf", err_ovf, 0);   chk("rst_xfer_cnt", xfer_cnt, 0);
    chk("rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      rd_data = tbl[i].rd;
      step(tbl[i].sel, tbl[i].cap, tbl[i].sh, tbl[i].upd, tbl[i].ti, tbl[i].rdy, 0);
      chk($sformatf("vec%0d_tdo", i),     tdo,         tbl[i].e_tdo);
      chk($sformatf("vec%0d_valid", i),   cmd_valid,   tbl[i].e_valid);
      chk($sformatf("vec%0d_err_len", i), err_len,     tbl[i].e_len);
      chk($sformatf("vec%0d_state", i),   dbg_state,   tbl[i].e_state);
      chk($sformatf("vec%0d_bit_cnt", i), dbg_bit_cnt, tbl[i].e_cnt);
    end
    tlr_pulse();
    chk("tlr_clears_err_len", err_len, 0);

    // readback: tdo shows rd_data bit i after shift i
    w1 = 32'hA5A5_0F0F;
    rd_data = w1;
    step(1, 1, 0, 0, 0, 0, 0);
    chk("rb_tdo_0", tdo, w1[0]);
    for (int i = 0; i < W; i++) begin
      step(1, 0, 1, 0, 0, 0, 0);
      chk($sformatf("rb_tdo_%0d", i + 1), tdo, (i + 1 < W) ? w1[(i + 1) % W] : 1'b0);
    end

    // full-length command and handshake
    tlr_pulse();
    cap_shift(32'h1234_5678, 32'hDEAD_BEEF, W, 0);
    do_update(0);
    chk("cmd_valid_after_update", cmd_valid, 1);
    chk("cmd_data_deadbeef", cmd_data, 32'hDEAD_BEEF);
    step(1, 0, 0, 0, 0, 1, 0);
    chk("cmd_valid_after_accept", cmd_valid, 0);
    chk("xfer_cnt_one", xfer_cnt, 1);

    // short and long scans
    cap_shift(32'h0, 32'h0F0F_F0F0, W - 1, 0);
    do_update(0);
    chk("short_err_len", err_len, 1);
    chk("short_no_cmd", cmd_valid, 0);
    tlr_pulse();
    cap_shift(32'h0, 32'h0F0F_F0F0, W + 2, 0);
    chk("long_bit_cnt_sat", dbg_bit_cnt, W + 1);
    do_update(0);
    chk("long_err_len", err_len, 1);
    chk("long_no_cmd", cmd_valid, 0);

    // overflow and same-edge handshake
    tlr_pulse();
    w1 = 32'h1111_1111; w2 = 32'h2222_2222;
    cap_shift(32'h0, w1, W, 0);
    do_update(0);
    cap_shift(32'h0, w2, W, 0);
    do_update(1);
    chk("same_edge_no_ovf", err_ovf, 0);
    chk("same_edge_data", cmd_data, w2);
    chk("same_edge_valid", cmd_valid, 1);
    chk("same_edge_cnt", xfer_cnt, 1);
    cap_shift(32'h0, 32'h3333_3333, W, 0);
    do_update(0);
    chk("ovf_set", err_ovf, 1);
    chk("ovf_keeps_data", cmd_data, w2);

    // test_logic_reset mid-shift, then update without capture
    cap_shift(32'hFFFF_FFFF, 32'h0, 10, 0);
    tlr_pulse();
    chk("tlr_state", dbg_state, 0);
    chk("tlr_tdo", tdo, 0);
    chk("tlr_err_ovf", err_ovf, 0);
    chk("tlr_valid", cmd_valid, 0);
    do_update(0);
    chk("orphan_update_err_len", err_len, 0);
    chk("orphan_update_valid", cmd_valid, 0);

    // randomized scans
    for (int k = 0; k < 40; k++) begin
      int len;
      case ($urandom_range(0, 4))
        0: len = W - 1;
        1: len = W + 1;
        default: len = W;
      endcase
      cap_shift($urandom, $urandom, len, 1);
      do_update(1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) step(1'($urandom_range(0, 1)), 0, 0, 0, 0, 1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 15) == 0) tlr_pulse();
    end

    // counter wrap
    tlr_pulse();
    for (int k = 0; k < (1 << CW) - 1; k++) begin
      cap_shift(32'h0, $urandom, W, 0);
      do_update(0);
      step(1, 0, 0, 0, 0, 1, 0);
    end
    chk("xfer_cnt_max", xfer_cnt, (1 << CW) - 1);
    cap_shift(32'h0, $urandom, W, 0);
    do_update(0);
    step(1, 0, 0, 0, 0, 1, 0);
    chk("xfer_cnt_wrap", xfer_cnt, 0);

    // asynchronous reset mid-scan with everything non-zero
    cap_shift(32'h0, 32'hCAFE_F00D, W, 0);
    do_update(0);
    step(1, 0, 0, 0, 0, 1, 0);
    cap_shift(32'h0, 32'hCAFE_F00D, W, 0);
    do_update(0);
    cap_shift(32'h0, 32'h0, W, 0);
    do_update(0);
    cap_shift(32'h0, 32'h0, 3, 0);
    do_update(0);
    cap_shift(32'hFFFF_FFFF, 32'h0, 5, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tdo", tdo, 0);           chk("arst_valid", cmd_valid, 0);
    chk("arst_data", cmd_data, 0);     chk("arst_err_len", err_len, 0);
    chk("arst_err_ovf", err_ovf, 0);   chk("arst_xfer_cnt", xfer_cnt, 0);
    chk("arst_state", dbg_state, 0);   chk("arst_bit_cnt", dbg_bit_cnt, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
